alu_share_ctrl: RTL

//  Sequencer/arbiter sharing one WIDTH-bit ALU core (AND/OR/XOR/ADD) between two requesters.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu4_core.sv | 42 ++++
 rtl/alu_share_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared definitions for the shared-ALU controller: ALU op codes
//             and the controller FSM state encoding.
//  Contents : op_e    - 2-bit op code (AND/OR/XOR/ADD)
//             state_e - 2-bit controller state (IDLE/EXEC/RESP)
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_ADD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu4_core.sv
`default_nettype none
// ============================================================================
//  Module   : alu4_core
//  Purpose  : Purely combinational ALU datapath: bitwise AND/OR/XOR and ADD
//             with carry-out.
//  Ports    : op   in  2      op code (see alu_pkg::op_e)
//             a    in  WIDTH  operand a
//             b    in  WIDTH  operand b
//             y    out WIDTH  result
//             cout out 1      carry-out of ADD, 0 for logic ops
//  Revision : 1.0 - initial release
// ============================================================================
module alu4_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             cout
);

    // Zero-extend both operands so the top bit of the sum is the carry.
    logic [WIDTH:0] w_sum;
    assign w_sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        y    = '0;
        cout = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_ADD:  {cout, y} = w_sum;
            default: y = '0;
        endcase
    end

endmodule : alu4_core
`default_nettype wire

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_share_ctrl
//  Purpose  : Shares one ALU core between two requesters. Round-robin grant,
//             valid/ready request and response channels, one op in flight,
//             registered result (IDLE -> EXEC -> RESP -> IDLE).
//  Ports    : clk, rst_n                 clock / async active-low reset
//             reqN_valid/ready           request handshake, N = 0,1
//             reqN_op/a/b                op code and operands
//             respN_valid/ready          response handshake, N = 0,1
//             resp_y, resp_cout          shared registered result
//             busy                       high while an op is in EXEC or RESP
//  Revision : 1.0 - initial release
// ============================================================================
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_y,
    output logic             resp_cout,
    output logic             busy
);

    state_e           r_state;
    logic             r_last_grant;
    logic             r_grant;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_y;
    logic             r_cout;
    logic             r_resp0_valid;
    logic             r_resp1_valid;
    logic             r_busy;

    logic             w_idle;
    logic             w_any;
    logic             w_grant;
    logic             w_accept;
    logic             w_resp_hs;
    logic [WIDTH-1:0] w_y;
    logic             w_cout;

    // Arbitration: a lone requester wins; on contention the one that was
    // not served last wins.
    assign w_idle  = (r_state == ST_IDLE);
    assign w_any   = req0_valid | req1_valid;
    assign w_grant = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

    // Ready is forced low while reset is asserted so nothing looks accepted.
    assign req0_ready = rst_n & w_idle & w_any & ~w_grant;
    assign req1_ready = rst_n & w_idle & w_any &  w_grant;
    assign w_accept   = req0_ready | req1_ready;

    assign w_resp_hs  = (r_state == ST_RESP) &
                        (r_grant ? resp1_ready : resp0_ready);

    alu4_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op   (r_op),
        .a    (r_a),
        .b    (r_b),
        .y    (w_y),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= 1'b1;
            r_grant       <= 1'b0;
            r_op          <= 2'b00;
            r_a           <= '0;
            r_b           <= '0;
            r_y           <= '0;
            r_cout        <= 1'b0;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_grant <= w_grant;
                        r_op    <= w_grant ? req1_op : req0_op;
                        r_a     <= w_grant ? req1_a  : req0_a;
                        r_b     <= w_grant ? req1_b  : req0_b;
                        r_busy  <= 1'b1;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_y           <= w_y;
                    r_cout        <= w_cout;
                    r_resp0_valid <= ~r_grant;
                    r_resp1_valid <=  r_grant;
                    r_state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_resp_hs) begin
                        r_last_grant  <= r_grant;
                        r_resp0_valid <= 1'b0;
                        r_resp1_valid <= 1'b0;
                        r_busy        <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign resp_y      = r_y;
    assign resp_cout   = r_cout;
    assign resp0_valid = r_resp0_valid;
    assign resp1_valid = r_resp1_valid;
    assign busy        = r_busy;

endmodule : alu_share_ctrl
`default_nettype wire
